// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl
// ----------------------------------------------------------------------------
// Instruction fetch sequencer that sits in front of the fetch pipeline
// register. It owns the fetch PC, issues one instruction-bus request at a
// time, and presents each fetched {pc, instr} pair to the fetch register
// until that register accepts it. Redirects from execute (branch, jump,
// exception) override everything. A fetch that is already on the bus when a
// redirect arrives is still allowed to complete, and its data is then
// thrown away.
//
// Parameters
//   XLEN      PC / address width (default 64)
//   ILEN      instruction width (default 32)
//   RESET_PC  PC of the first fetch after reset (default 64'h8000_0000)
//
// Ports
//   clk             in   1     clock
//   reset           in   1     synchronous, active-high reset
//   ireq_valid      out  1     instruction-bus request valid
//   ireq_addr       out  XLEN  request address, always 4-byte aligned
//   iresp_ok        in   1     bus response; completes the outstanding request
//   iresp_data      in   ILEN  fetched instruction, valid with iresp_ok
//   redirect_valid  in   1     redirect request from execute
//   redirect_pc     in   XLEN  redirect target (low two bits ignored)
//   stall           in   1     fetch register cannot accept this cycle
//   out_valid       out  1     {out_pc, out_instr} is presented
//   out_pc          out  XLEN  PC of the presented instruction
//   out_instr       out  ILEN  presented instruction, 0 when out_valid=0
//
// Optional feature (macro FETCH_CTRL_PERF_EN)
//   When defined, two extra outputs are added:
//   perf_fetched    out  64    +1 for every instruction the fetch register accepts
//   perf_stall_cyc  out  64    +1 for every cycle an instruction waits on stall
//   Both counters clear on reset and wrap at 2^64. When the macro is left
//   undefined, the ports and counters are absent. Fetch behaviour is the
//   same in both builds.
// ============================================================================
module fetch_ctrl #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_ok,
    input  logic [ILEN-1:0] iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_stall_cyc
`endif
);

    // IDLE    : nothing on the bus; a request is launched on the next cycle
    // REQ     : request on the bus, waiting for iresp_ok
    // HOLD    : instruction presented, waiting for the fetch register to take it
    // DISCARD : request on the bus has been made stale by a redirect
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    // Clears the two low address bits so every PC stays word aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state,           state_next;
    logic [XLEN-1:0] pc,              pc_next;
    logic            ireq_valid_next;
    logic [XLEN-1:0] ireq_addr_next;
    logic            out_valid_next;
    logic [XLEN-1:0] out_pc_next;
    logic [ILEN-1:0] out_instr_next;

    logic            consume;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_inc;

    // The fetch register accepts the presented instruction only when the
    // instruction is not stalled and is not being squashed in the same cycle.
    assign consume         = out_valid & ~stall & ~redirect_valid;
    assign redirect_target = redirect_pc & ALIGN_MASK;
    // Wraps naturally at 2^XLEN.
    assign pc_inc          = pc + XLEN'(4);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal is first given its hold value, so each path
        // through the case below assigns it and no latch is inferred.
        state_next      = state;
        pc_next         = pc;
        ireq_valid_next = ireq_valid;
        ireq_addr_next  = ireq_addr;
        out_valid_next  = out_valid;
        out_pc_next     = out_pc;
        out_instr_next  = out_instr;

        unique case (state)
            S_IDLE: begin
                // A redirect here only retargets the request that is about to launch.
                state_next      = S_REQ;
                ireq_valid_next = 1'b1;
                if (redirect_valid) begin
                    pc_next        = redirect_target;
                    ireq_addr_next = redirect_target;
                end else begin
                    ireq_addr_next = pc;
                end
            end

            S_REQ: begin
                // The request is never withdrawn. Address and valid stay put
                // until the bus completes the request.
                if (redirect_valid) begin
                    pc_next        = redirect_target;
                    out_valid_next = 1'b0;
                    out_instr_next = '0;
                    if (iresp_ok) begin
                        // The bus finished in the same cycle. Drop the data
                        // and restart cleanly from IDLE.
                        state_next      = S_IDLE;
                        ireq_valid_next = 1'b0;
                    end else begin
                        state_next = S_DISCARD;
                    end
                end else if (iresp_ok) begin
                    state_next      = S_HOLD;
                    ireq_valid_next = 1'b0;
                    out_valid_next  = 1'b1;
                    out_pc_next     = ireq_addr;
                    out_instr_next  = iresp_data;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // Squash the held instruction even while it is stalled.
                    state_next     = S_IDLE;
                    pc_next        = redirect_target;
                    out_valid_next = 1'b0;
                    out_instr_next = '0;
                end else if (consume) begin
                    // Launch the sequential fetch directly, without passing through IDLE.
                    state_next      = S_REQ;
                    pc_next         = pc_inc;
                    ireq_valid_next = 1'b1;
                    ireq_addr_next  = pc_inc;
                    out_valid_next  = 1'b0;
                    out_instr_next  = '0;
                end
            end

            S_DISCARD: begin
                // The stale request stays on the bus until it completes.
                // pc already holds the redirect target.
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (iresp_ok) begin
                        state_next      = S_IDLE;
                        ireq_valid_next = 1'b0;
                    end
                end else if (iresp_ok) begin
                    state_next      = S_REQ;
                    ireq_valid_next = 1'b1;
                    ireq_addr_next  = pc;
                end
            end

            default: begin
                state_next      = S_IDLE;
                ireq_valid_next = 1'b0;
                out_valid_next  = 1'b0;
                out_instr_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples the
        // values from before this clock edge, whatever order the lines are in.
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC & ALIGN_MASK;
            ireq_valid <= 1'b0;
            ireq_addr  <= '0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ireq_valid <= ireq_valid_next;
            ireq_addr  <= ireq_addr_next;
            out_valid  <= out_valid_next;
            out_pc     <= out_pc_next;
            out_instr  <= out_instr_next;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^64)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (consume) begin
                perf_fetched <= perf_fetched + 64'd1;
            end
            if (out_valid && stall) begin
                perf_stall_cyc <= perf_stall_cyc + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for fetch_ctrl. Inputs are driven 1 time unit after
// each rising clock edge, and outputs are sampled at the same point. Each
// check therefore sees the register values produced by the edge just passed.
// Define FETCH_CTRL_PERF_EN to also exercise the performance counters.
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_CTRL_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_stall_cyc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_ok       (iresp_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects a request for addr on the bus now. Waits one cycle of bus
    // latency, then answers with data. Afterwards the instruction should be
    // presented.
    task automatic fetch_one(input string tag, input logic [63:0] addr, input logic [31:0] data);
        check({tag, ":req_v"}, 64'(ireq_valid), 64'd1);
        check({tag, ":req_a"}, ireq_addr, addr);
        tick();
        check({tag, ":req_hold"}, ireq_addr, addr);
        check({tag, ":no_out"}, 64'(out_valid), 64'd0);
        iresp_ok   = 1'b1;
        iresp_data = data;
        tick();
        iresp_ok   = 1'b0;
        iresp_data = '0;
        check({tag, ":out_v"}, 64'(out_valid), 64'd1);
        check({tag, ":out_pc"}, out_pc, addr);
        check({tag, ":out_i"}, 64'(out_instr), 64'(data));
        check({tag, ":req_drop"}, 64'(ireq_valid), 64'd0);
    endtask

    // The fetch register takes the instruction (stall is low). The next
    // sequential request must follow immediately.
    task automatic consume(input string tag, input logic [63:0] next_addr);
        stall = 1'b0;
        tick();
        check({tag, ":pulse_end"}, 64'(out_valid), 64'd0);
        check({tag, ":instr_zero"}, 64'(out_instr), 64'd0);
        check({tag, ":next_v"}, 64'(ireq_valid), 64'd1);
        check({tag, ":next_a"}, ireq_addr, next_addr);
    endtask

    // Leaves the DUT in REQ with the RESET_PC request on the bus.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        iresp_ok       = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst:ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst:ireq_addr", ireq_addr, 64'd0);
        check("rst:out_valid", 64'(out_valid), 64'd0);
        check("rst:out_pc", out_pc, 64'd0);
        check("rst:out_instr", 64'(out_instr), 64'd0);

        // ---- 1: straight-line fetch, 1-clk bus, no stall ----
        reset = 1'b0;
        tick();
        fetch_one("t1a", 64'h8000_0000, 32'h0000_0013);
        consume("t1a", 64'h8000_0004);
        fetch_one("t1b", 64'h8000_0004, 32'h0010_0093);
        consume("t1b", 64'h8000_0008);
        fetch_one("t1c", 64'h8000_0008, 32'hdead_beef);
        consume("t1c", 64'h8000_000c);

        // ---- 2: stall holds the output for 5 clk, with no new request ----
        do_reset();
        stall = 1'b1;
        fetch_one("t2", 64'h8000_0000, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2:held_v", 64'(out_valid), 64'd1);
            check("t2:held_i", 64'(out_instr), 64'h1234_5678);
            check("t2:no_req", 64'(ireq_valid), 64'd0);
        end
        consume("t2", 64'h8000_0004);

        // ---- 3: redirect while waiting on a slow bus (response 4 clk late) ----
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1003;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3:stale_v", 64'(ireq_valid), 64'd1);
            check("t3:stale_a", ireq_addr, 64'h8000_0000);
            check("t3:no_out", 64'(out_valid), 64'd0);
            if (i < 2) tick();
        end
        iresp_ok   = 1'b1;
        iresp_data = 32'hbad0_0001;
        tick();
        iresp_ok   = 1'b0;
        iresp_data = '0;
        check("t3:dropped", 64'(out_valid), 64'd0);
        fetch_one("t3", 64'h8000_1000, 32'h0000_1111);
        consume("t3", 64'h8000_1004);

        // ---- 4: redirect in HOLD while stalled ----
        fetch_one("t4", 64'h8000_1004, 32'h00a0_0513);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check("t4:squash_v", 64'(out_valid), 64'd0);
        check("t4:squash_i", 64'(out_instr), 64'd0);
        check("t4:idle", 64'(ireq_valid), 64'd0);
        tick();
        check("t4:tgt_v", 64'(ireq_valid), 64'd1);
        check("t4:tgt_a", ireq_addr, 64'h8000_2000);

        // ---- 5: redirect and response in the same cycle ----
        tick();
        iresp_ok       = 1'b1;
        iresp_data     = 32'hbad0_0005;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3008;
        tick();
        iresp_ok       = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        check("t5:no_out", 64'(out_valid), 64'd0);
        check("t5:idle", 64'(ireq_valid), 64'd0);
        tick();
        check("t5:no_out2", 64'(out_valid), 64'd0);
        check("t5:tgt_v", 64'(ireq_valid), 64'd1);
        check("t5:tgt_a", ireq_addr, 64'h8000_3008);

        // ---- PC wrap at the top of the address space ----
        tick();
        iresp_ok       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hffff_ffff_ffff_ffff;
        tick();
        iresp_ok       = 1'b0;
        redirect_valid = 1'b0;
        tick();
        fetch_one("wrap", 64'hffff_ffff_ffff_fffc, 32'h0000_0073);
        consume("wrap", 64'h0000_0000_0000_0000);

        // ---- reset mid-transfer, late response ignored ----
        reset = 1'b1;
        tick();
        check("rmid:req", 64'(ireq_valid), 64'd0);
        check("rmid:out", 64'(out_valid), 64'd0);
        reset      = 1'b0;
        iresp_ok   = 1'b1;
        iresp_data = 32'hffff_ffff;
        tick();
        iresp_ok   = 1'b0;
        iresp_data = '0;
        check("rmid:new_v", 64'(ireq_valid), 64'd1);
        check("rmid:new_a", ireq_addr, 64'h8000_0000);
        tick();
        check("rmid:ignored", 64'(out_valid), 64'd0);

        // ---- redirect in IDLE ----
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_4004;
        tick();
        redirect_valid = 1'b0;
        fetch_one("idle_rd", 64'h8000_4004, 32'h0000_4444);
        consume("idle_rd", 64'h8000_4008);

`ifdef FETCH_CTRL_PERF_EN
        // ---- 6: performance counters ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            fetch_one("perf", 64'h8000_0000 + 64'(4 * i), 32'(i + 1));
            if (i < 7) begin
                stall = 1'b1;
                tick();
                stall = 1'b0;
            end
            consume("perf", 64'h8000_0000 + 64'(4 * (i + 1)));
        end
        check("perf:fetched", perf_fetched, 64'd10);
        check("perf:stall", perf_stall_cyc, 64'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("perf:rst_fetched", perf_fetched, 64'd0);
        check("perf:rst_stall", perf_stall_cyc, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
